delay_meas_ctrl: RTL and testbench
==================================

# delay_meas_ctrl

Sequencer for the on-chip inverter-chain delay experiment. It enables the inverter ring and selects its tap length. It then waits for the ring to settle, counts ring-oscillator rising edges over a fixed gate window of system clocks, and latches the count for readout. It sits between the user I/O (start, tap select) and the ring-oscillator macro (enable, tap, oscillator output).

## Interface
- SETTLE_CYCLES, 16 — clocks the ring runs enabled before counting starts (≥1)
- GATE_CYCLES, 1024 — clocks in the counting window (≥1)
- CNT_W, 16 — width of edge counter and result
- TAP_W, 3 — width of tap select
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  level; sampled only in IDLE, launches one measurement
- abort  in  1  level; returns to IDLE from any state
- tap_sel  in  TAP_W  requested chain length, captured at start
- osc_in  in  1  ring-oscillator output, asynchronous to clk
- osc_en  out  1  ring enable
- tap  out  TAP_W  tap select driven to the ring, stable for the whole measurement
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, result newly valid
- result  out  CNT_W  latched edge count of last completed measurement
- ovf  out  1  last result saturated

## Operation
- States: IDLE, SETTLE, GATE, DONE. A single down-counter (width ≥ clog2 of the larger of SETTLE_CYCLES and GATE_CYCLES) times SETTLE and GATE.
- IDLE: osc_en=0. If start=1 and abort=0: tap←tap_sel, timer←SETTLE_CYCLES-1, edge counter←0, go SETTLE.
- SETTLE: osc_en=1. Edges are not counted. When timer=0: timer←GATE_CYCLES-1, go GATE; else decrement.
- GATE: osc_en=1. Each synchronized rising edge increments the counter. The counter saturates at 2^CNT_W-1 and sets an internal overflow flag. When timer=0, go DONE. An edge detected in that final GATE cycle is counted.
- DONE: osc_en=0. result←counter, ovf←overflow flag, done=1. Go IDLE unconditionally.
- osc_in path: 2-flop synchronizer, plus a third flop for the previous value. rising = s2 & ~s3. The synchronizer runs continuously, including in IDLE.
- abort=1 in SETTLE/GATE/DONE: next state IDLE, osc_en=0 next cycle, result/ovf unchanged, no done pulse. Abort has priority over start and over the DONE transition.
- start held high across DONE→IDLE starts a new measurement from IDLE one cycle later. Start is ignored while busy.
- tap holds its value after the measurement until the next start.
- Counts are meaningful only if f_osc < f_clk/2. Aliasing above that is not detected.

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE, osc_en=0, tap=0, busy=0, done=0, result=0, ovf=0, counter/timer=0, synchronizer flops=0. rst_n mid-measurement behaves like abort and also clears result/ovf.
- start sampled at edge N (IDLE): cycles N+1..N+SETTLE_CYCLES are SETTLE. The next GATE_CYCLES cycles are GATE. The following cycle is DONE (done=1, result valid at that edge's output). The cycle after that is IDLE.
- Total busy duration = SETTLE_CYCLES + GATE_CYCLES + 1 cycles. Minimum start-to-start period = that + 1.
- osc_en is high for exactly SETTLE_CYCLES + GATE_CYCLES cycles.
- Synchronizer latency: an osc_in rising edge is seen as `rising` 2–3 clk later. Edges up to 3 cycles before GATE can therefore be counted, and edges in the last 2 GATE cycles are lost. This is accepted systematic error.

## Test plan
- Reset: hold rst_n=0 for 3 clk with start=1 → all outputs 0. Release with start=0 → remain IDLE, busy=0.
- Basic count (SETTLE=4, GATE=40): osc_in toggles every 2 clk (period 4) from time 0, start pulsed → busy for 45 cycles, osc_en high for 44, done single pulse, result=10±1, ovf=0, tap=tap_sel.
- Saturation (CNT_W=3, GATE=64, osc period 4 clk) → result=7, ovf=1. A following run with osc_in static → result=0, ovf=0.
- Abort in GATE cycle 10 → osc_en low next cycle, busy low, no done pulse, result keeps previous value. A new start then measures normally.
- start held high continuously → back-to-back measurements, one IDLE cycle between busy periods, one done per measurement. A tap_sel change mid-measurement does not alter tap until the next start.
- osc_in static high or low throughout → result=0. A single isolated edge placed mid-GATE → result=1.

Source files
------------

// File: rtl/delay_meas_ctrl.sv
// Inverter-chain delay experiment sequencer: enables the ring, lets it settle,
// counts synchronized ring-oscillator rising edges over a fixed clock window.
module delay_meas_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1024,
    parameter int CNT_W         = 16,
    parameter int TAP_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [TAP_W-1:0] tap_sel,
    input  logic             osc_in,
    output logic             osc_en,
    output logic [TAP_W-1:0] tap,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             ovf
);

    localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]         state;
    logic [TIMER_W-1:0] timer;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_flag;
    logic               ovf_inc;
    logic               sync1;
    logic               sync2;
    logic               sync3;
    logic               rising;

    // osc_in is asynchronous to clk; sync3 only holds the previous sample for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true shift chain; blocking would collapse it into one flop.
            sync1 <= osc_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rising = sync2 & ~sync3;

    // Next count including the current cycle's edge, so the final GATE cycle is counted.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        cnt_inc = cnt;
        ovf_inc = ovf_flag;
        if (state == ST_GATE && rising) begin
            if (cnt == {CNT_W{1'b1}}) begin
                ovf_inc = 1'b1;
            end else begin
                cnt_inc = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            tap      <= '0;
            result   <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        tap      <= tap_sel;
                        timer    <= TIMER_W'(SETTLE_CYCLES - 1);
                        cnt      <= '0;
                        ovf_flag <= 1'b0;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (timer == '0) begin
                        timer <= TIMER_W'(GATE_CYCLES - 1);
                        state <= ST_GATE;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                ST_GATE: begin
                    cnt      <= cnt_inc;
                    ovf_flag <= ovf_inc;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (timer == '0) begin
                        // Latch on DONE entry so result is already valid while done is high.
                        result <= cnt_inc;
                        ovf    <= ovf_inc;
                        state  <= ST_DONE;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign osc_en = (state == ST_SETTLE) || (state == ST_GATE);
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Directed bench for delay_meas_ctrl: two instances (16-bit and 3-bit counters),
// results checked against a queue of expected values filled when each run is launched.
module tb_delay_meas_ctrl;

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, abort_a, osc_a, osc_tog_a, osc_lvl_a;
    logic [2:0]  tap_sel_a, tap_a;
    logic        osc_en_a, busy_a, done_a, ovf_a;
    logic [15:0] result_a;
    logic        start_b, abort_b, osc_b, osc_tog_b, osc_lvl_b;
    logic [2:0]  tap_sel_b, tap_b;
    logic        osc_en_b, busy_b, done_b, ovf_b;
    logic [2:0]  result_b;

    logic        osc_gen = 1'b0;
    int unsigned osc_ph  = 0;

    exp_t exp_q_a[$];
    exp_t exp_q_b[$];
    int   pushed_a = 0, pushed_b = 0, done_cnt_a = 0, done_cnt_b = 0;
    int   busy_runs_a[$], osc_runs_a[$], idle_runs_a[$];
    int   busy_run_a = 0, osc_run_a = 0, idle_run_a = 0;
    int   n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    // Free-running ring model: period of 4 clocks, toggling away from the active edge.
    always @(negedge clk) begin
        osc_ph++;
        if (osc_ph % 2 == 0) osc_gen = ~osc_gen;
    end

    assign osc_a = osc_tog_a ? osc_gen : osc_lvl_a;
    assign osc_b = osc_tog_b ? osc_gen : osc_lvl_b;

    delay_meas_ctrl #(.SETTLE_CYCLES(4), .GATE_CYCLES(40), .CNT_W(16), .TAP_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .tap_sel(tap_sel_a),
        .osc_in(osc_a), .osc_en(osc_en_a), .tap(tap_a), .busy(busy_a), .done(done_a),
        .result(result_a), .ovf(ovf_a)
    );

    delay_meas_ctrl #(.SETTLE_CYCLES(4), .GATE_CYCLES(64), .CNT_W(3), .TAP_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .tap_sel(tap_sel_b),
        .osc_in(osc_b), .osc_en(osc_en_b), .tap(tap_b), .busy(busy_b), .done(done_b),
        .result(result_b), .ovf(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard and run-length monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (done_a) begin
                done_cnt_a++;
                check("a_done_expected", exp_q_a.size() != 0, 1);
                if (exp_q_a.size() != 0) begin
                    e = exp_q_a.pop_front();
                    check("a_result", result_a, e.res);
                    check("a_ovf", ovf_a, e.ovf);
                end
            end
            if (done_b) begin
                done_cnt_b++;
                check("b_done_expected", exp_q_b.size() != 0, 1);
                if (exp_q_b.size() != 0) begin
                    e = exp_q_b.pop_front();
                    check("b_result", result_b, e.res);
                    check("b_ovf", ovf_b, e.ovf);
                end
            end
            if (busy_a) begin
                busy_run_a++;
                if (idle_run_a != 0) begin idle_runs_a.push_back(idle_run_a); idle_run_a = 0; end
            end else begin
                idle_run_a++;
                if (busy_run_a != 0) begin busy_runs_a.push_back(busy_run_a); busy_run_a = 0; end
            end
            if (osc_en_a) osc_run_a++;
            else if (osc_run_a != 0) begin osc_runs_a.push_back(osc_run_a); osc_run_a = 0; end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        wait_clk(1);
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        wait_clk(1);
        start_b = 1'b0;
    endtask

    task automatic push_a(input logic [15:0] res, input logic o);
        exp_q_a.push_back('{res: res, ovf: o});
        pushed_a++;
    endtask

    task automatic push_b(input logic [15:0] res, input logic o);
        exp_q_b.push_back('{res: res, ovf: o});
        pushed_b++;
    endtask

    task automatic run_until_idle_a(input int max_cyc);
        int i = 0;
        while (busy_a && i < max_cyc) begin wait_clk(1); i++; end
        check("a_idle_within_budget", busy_a, 0);
        wait_clk(1);
    endtask

    task automatic run_until_idle_b(input int max_cyc);
        int i = 0;
        while (busy_b && i < max_cyc) begin wait_clk(1); i++; end
        check("b_idle_within_budget", busy_b, 0);
        wait_clk(1);
    endtask

    task automatic clear_runs_a();
        busy_runs_a.delete();
        osc_runs_a.delete();
        idle_runs_a.delete();
    endtask

    task automatic check_single_run_a(input string tag, input int busy_len, input int osc_len);
        check({tag, "_busy_runs"}, busy_runs_a.size(), 1);
        check({tag, "_busy_len"}, (busy_runs_a.size() > 0) ? busy_runs_a[0] : -1, busy_len);
        check({tag, "_osc_runs"}, osc_runs_a.size(), 1);
        check({tag, "_osc_en_len"}, (osc_runs_a.size() > 0) ? osc_runs_a[0] : -1, osc_len);
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b1; abort_a = 1'b0; tap_sel_a = 3'd5; osc_tog_a = 1'b1; osc_lvl_a = 1'b0;
        start_b = 1'b1; abort_b = 1'b0; tap_sel_b = 3'd3; osc_tog_b = 1'b1; osc_lvl_b = 1'b0;

        // Reset held with start asserted.
        wait_clk(3);
        check("rst_a_osc_en", osc_en_a, 0);
        check("rst_a_tap", tap_a, 0);
        check("rst_a_busy", busy_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_a_result", result_a, 0);
        check("rst_a_ovf", ovf_a, 0);
        check("rst_b_busy", busy_b, 0);
        check("rst_b_result", result_b, 0);
        rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
        wait_clk(3);
        check("post_rst_a_busy", busy_a, 0);
        check("post_rst_b_busy", busy_b, 0);

        // Basic count: 40-clock window, edge every 4 clocks -> 10.
        clear_runs_a();
        push_a(16'd10, 1'b0);
        pulse_start_a();
        run_until_idle_a(100);
        check("basic_tap", tap_a, 5);
        check_single_run_a("basic", 45, 44);

        // Abort in GATE cycle 10.
        clear_runs_a();
        pulse_start_a();
        wait_clk(13);
        check("abort_pre_busy", busy_a, 1);
        check("abort_pre_osc_en", osc_en_a, 1);
        abort_a = 1'b1;
        wait_clk(1);
        abort_a = 1'b0;
        check("abort_osc_en", osc_en_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_result_kept", result_a, 10);
        wait_clk(1);
        check_single_run_a("abort", 14, 14);

        // Normal run after abort.
        clear_runs_a();
        push_a(16'd10, 1'b0);
        pulse_start_a();
        run_until_idle_a(100);
        check_single_run_a("post_abort", 45, 44);

        // Static high, static low.
        osc_tog_a = 1'b0; osc_lvl_a = 1'b1;
        wait_clk(5);
        push_a(16'd0, 1'b0);
        pulse_start_a();
        run_until_idle_a(100);
        osc_lvl_a = 1'b0;
        wait_clk(5);
        push_a(16'd0, 1'b0);
        pulse_start_a();
        run_until_idle_a(100);

        // One isolated rising edge mid-window.
        push_a(16'd1, 1'b0);
        pulse_start_a();
        wait_clk(20);
        osc_lvl_a = 1'b1;
        run_until_idle_a(100);
        osc_lvl_a = 1'b0;
        wait_clk(5);

        // Start held high: three back-to-back runs, tap_sel changed mid-run.
        osc_tog_a = 1'b1;
        wait_clk(5);
        clear_runs_a();
        push_a(16'd10, 1'b0);
        push_a(16'd10, 1'b0);
        push_a(16'd10, 1'b0);
        tap_sel_a = 3'd2;
        start_a = 1'b1;
        wait_clk(11);
        check("b2b_tap_first", tap_a, 2);
        tap_sel_a = 3'd6;
        idle_runs_a.delete();
        wait_clk(5);
        check("b2b_tap_held", tap_a, 2);
        wait_clk(84);
        start_a = 1'b0;
        check("b2b_tap_second", tap_a, 6);
        run_until_idle_a(100);
        check("b2b_busy_runs", busy_runs_a.size(), 3);
        for (int k = 0; k < 3; k++)
            check("b2b_busy_len", (k < busy_runs_a.size()) ? busy_runs_a[k] : -1, 45);
        check("b2b_idle_runs", idle_runs_a.size(), 2);
        for (int k = 0; k < 2; k++)
            check("b2b_idle_len", (k < idle_runs_a.size()) ? idle_runs_a[k] : -1, 1);
        check("a_done_count", done_cnt_a, pushed_a);
        check("a_queue_empty", exp_q_a.size(), 0);

        // Saturation on the 3-bit instance: 16 edges in 64 clocks -> 7 with overflow.
        push_b(16'd7, 1'b1);
        pulse_start_b();
        run_until_idle_b(150);
        check("sat_tap", tap_b, 3);
        osc_tog_b = 1'b0; osc_lvl_b = 1'b0;
        wait_clk(5);
        push_b(16'd0, 1'b0);
        pulse_start_b();
        run_until_idle_b(150);
        check("b_done_count", done_cnt_b, pushed_b);
        check("b_queue_empty", exp_q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
